// File: rtl/axi_irq_ctrl.sv
// AXI-lite interrupt controller (edge/level sources, EOI clear); FORCE reg at 0x00C only with IRQ_CTRL_FORCE_EN.
// One-cycle aw/w/ar accept pulses; B/R responses held until bready/rready; o_irq lags PENDING by one cycle.
module axi_irq_ctrl #(
    parameter int AXI_ADDR_BW_p = 12,
    parameter int IRQ_NBR_p     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [AXI_ADDR_BW_p-1:0] i_axi_awaddr,
    input  logic                     i_axi_awvalid,
    output logic                     o_axi_awready,
    input  logic [31:0]              i_axi_wdata,
    input  logic [3:0]               i_axi_wstrb,
    input  logic                     i_axi_wvalid,
    output logic                     o_axi_wready,
    output logic [1:0]               o_axi_bresp,
    output logic                     o_axi_bvalid,
    input  logic                     i_axi_bready,
    input  logic [AXI_ADDR_BW_p-1:0] i_axi_araddr,
    input  logic                     i_axi_arvalid,
    output logic                     o_axi_arready,
    output logic [31:0]              o_axi_rdata,
    output logic [1:0]               o_axi_rresp,
    output logic                     o_axi_rvalid,
    input  logic                     i_axi_rready,
    input  logic [IRQ_NBR_p-1:0]     i_irq_src,
    input  logic [IRQ_NBR_p-1:0]     i_eoi,
    output logic [IRQ_NBR_p-1:0]     o_irq
);
    localparam logic [AXI_ADDR_BW_p-1:0] OFS_PEND  = AXI_ADDR_BW_p'('h000);
    localparam logic [AXI_ADDR_BW_p-1:0] OFS_EN    = AXI_ADDR_BW_p'('h004);
    localparam logic [AXI_ADDR_BW_p-1:0] OFS_MODE  = AXI_ADDR_BW_p'('h008);
    localparam logic [AXI_ADDR_BW_p-1:0] OFS_FORCE = AXI_ADDR_BW_p'('h00C);
    localparam logic [AXI_ADDR_BW_p-1:0] OFS_ACT   = AXI_ADDR_BW_p'('h010);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_DATA} rd_state_t;

    wr_state_t wr_state_q, wr_state_d;
    rd_state_t rd_state_q, rd_state_d;
    logic [IRQ_NBR_p-1:0] pending_q, pending_d, enable_q, enable_d, mode_q, mode_d;
    logic [IRQ_NBR_p-1:0] src_q, eoi_q, irq_q;
    logic [IRQ_NBR_p-1:0] wd, wm, set_v, clr_v;
    logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d, rd_val, wmask;
    logic        wr_fire, rd_fire, wr_ok, rd_ok;
    logic        wr_pend, wr_en, wr_mode, wr_force;
    logic        unused_bits;

    // Accept pulses are gated by reset so the bus sees nothing while rst is held.
    assign wr_fire = (wr_state_q == W_IDLE) && i_axi_awvalid && i_axi_wvalid && !rst;
    assign rd_fire = (rd_state_q == R_IDLE) && i_axi_arvalid && !rst;

    assign wmask = {{8{i_axi_wstrb[3]}}, {8{i_axi_wstrb[2]}}, {8{i_axi_wstrb[1]}}, {8{i_axi_wstrb[0]}}};
    assign wm    = wmask[IRQ_NBR_p-1:0];
    assign wd    = i_axi_wdata[IRQ_NBR_p-1:0] & wm;
    assign unused_bits = ^{i_axi_wdata, wmask};

    always_comb begin
        wr_ok    = 1'b0;
        wr_pend  = 1'b0;
        wr_en    = 1'b0;
        wr_mode  = 1'b0;
        wr_force = 1'b0;
        case (i_axi_awaddr)
            OFS_PEND: begin wr_ok = 1'b1; wr_pend = wr_fire; end
            OFS_EN:   begin wr_ok = 1'b1; wr_en   = wr_fire; end
            OFS_MODE: begin wr_ok = 1'b1; wr_mode = wr_fire; end
`ifdef IRQ_CTRL_FORCE_EN
            OFS_FORCE: begin wr_ok = 1'b1; wr_force = wr_fire; end
`endif
            OFS_ACT:  wr_ok = 1'b1;
            default:  wr_ok = 1'b0;
        endcase
    end

    always_comb begin
        rd_ok  = 1'b1;
        rd_val = '0;
        case (i_axi_araddr)
            OFS_PEND: rd_val[IRQ_NBR_p-1:0] = pending_q;
            OFS_EN:   rd_val[IRQ_NBR_p-1:0] = enable_q;
            OFS_MODE: rd_val[IRQ_NBR_p-1:0] = mode_q;
`ifdef IRQ_CTRL_FORCE_EN
            OFS_FORCE: rd_val = '0;
`endif
            OFS_ACT:  rd_val[IRQ_NBR_p-1:0] = pending_q & enable_q;
            default:  rd_ok = 1'b0;
        endcase
    end

    // Set is OR-ed in after clear, so a source still asserted re-pends in the same cycle.
    always_comb begin
        set_v     = (mode_q & i_irq_src & ~src_q) | (~mode_q & i_irq_src) | (wr_force ? wd : '0);
        clr_v     = (i_eoi & ~eoi_q) | (wr_pend ? wd : '0);
        pending_d = (pending_q & ~clr_v) | set_v;
        enable_d  = wr_en   ? ((enable_q & ~wm) | wd) : enable_q;
        mode_d    = wr_mode ? ((mode_q & ~wm) | wd)   : mode_q;
    end

    always_comb begin
        wr_state_d = wr_state_q;
        bresp_d    = bresp_q;
        case (wr_state_q)
            W_IDLE: if (wr_fire) begin
                wr_state_d = W_RESP;
                bresp_d    = wr_ok ? RESP_OKAY : RESP_SLVERR;
            end
            W_RESP: if (i_axi_bready) wr_state_d = W_IDLE;
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            R_IDLE: if (rd_fire) begin
                rd_state_d = R_DATA;
                rdata_d    = rd_val;
                rresp_d    = rd_ok ? RESP_OKAY : RESP_SLVERR;
            end
            R_DATA: if (i_axi_rready) rd_state_d = R_IDLE;
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_state_q <= W_IDLE;
            rd_state_q <= R_IDLE;
            pending_q  <= '0;
            enable_q   <= '0;
            mode_q     <= '0;
            src_q      <= '0;
            eoi_q      <= '0;
            irq_q      <= '0;
            bresp_q    <= '0;
            rresp_q    <= '0;
            rdata_q    <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            pending_q  <= pending_d;
            enable_q   <= enable_d;
            mode_q     <= mode_d;
            src_q      <= i_irq_src;
            eoi_q      <= i_eoi;
            irq_q      <= pending_q & enable_q;
            bresp_q    <= bresp_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
        end
    end

    assign o_axi_awready = wr_fire;
    assign o_axi_wready  = wr_fire;
    assign o_axi_bvalid  = (wr_state_q == W_RESP);
    assign o_axi_bresp   = bresp_q;
    assign o_axi_arready = rd_fire;
    assign o_axi_rvalid  = (rd_state_q == R_DATA);
    assign o_axi_rdata   = rdata_q;
    assign o_axi_rresp   = rresp_q;
    assign o_irq         = irq_q;
endmodule

// File: tb/tb_axi_irq_ctrl.sv
// Bench for axi_irq_ctrl: AXI responses go through an expected/actual scoreboard, IRQ pins are checked inline.
module tb_axi_irq_ctrl;
    localparam logic [11:0] A_PEND = 12'h000, A_EN = 12'h004, A_MODE = 12'h008;
    localparam logic [11:0] A_FORCE = 12'h00C, A_ACT = 12'h010, A_BAD = 12'h020;
    localparam logic [1:0]  OKAY = 2'b00, SLVERR = 2'b10;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        ok;
    } rsp_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic [11:0] awaddr = '0, araddr = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic [7:0]  irq_src = '0, eoi = '0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic [7:0]  irq;

    int   n_cmp = 0, n_err = 0;
    rsp_t exp_q[$], act_q[$];

    axi_irq_ctrl #(.AXI_ADDR_BW_p(12), .IRQ_NBR_p(8)) dut (
        .clk(clk), .rst(rst),
        .i_axi_awaddr(awaddr), .i_axi_awvalid(awvalid), .o_axi_awready(awready),
        .i_axi_wdata(wdata), .i_axi_wstrb(wstrb), .i_axi_wvalid(wvalid), .o_axi_wready(wready),
        .o_axi_bresp(bresp), .o_axi_bvalid(bvalid), .i_axi_bready(bready),
        .i_axi_araddr(araddr), .i_axi_arvalid(arvalid), .o_axi_arready(arready),
        .o_axi_rdata(rdata), .o_axi_rresp(rresp), .o_axi_rvalid(rvalid), .i_axi_rready(rready),
        .i_irq_src(irq_src), .i_eoi(eoi), .o_irq(irq)
    );

    always #5 clk = ~clk;

    task automatic bus_wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s, output rsp_t r);
        r = '{data: 32'h0, resp: 2'bxx, ok: 1'b0};
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (awready && wready) begin r.ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        if (r.ok) begin
            r.ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (bvalid) begin r.ok = 1'b1; r.resp = bresp; break; end
            end
            @(posedge clk); #1;
        end
        bready = 1'b0;
    endtask

    task automatic bus_rd(input logic [11:0] a, output rsp_t r);
        r = '{data: 32'hx, resp: 2'bxx, ok: 1'b0};
        araddr = a; arvalid = 1'b1; rready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (arready) begin r.ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        arvalid = 1'b0;
        if (r.ok) begin
            r.ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (rvalid) begin r.ok = 1'b1; r.data = rdata; r.resp = rresp; break; end
            end
            @(posedge clk); #1;
        end
        rready = 1'b0;
    endtask

    // Stimulus wrappers: the expectation enters the scoreboard before the transaction is driven.
    task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] er);
        rsp_t r;
        exp_q.push_back('{data: 32'h0, resp: er, ok: 1'b1});
        bus_wr(a, d, s, r);
        act_q.push_back(r);
    endtask

    task automatic rd(input logic [11:0] a, input logic [31:0] ed, input logic [1:0] er);
        rsp_t r;
        exp_q.push_back('{data: ed, resp: er, ok: 1'b1});
        bus_rd(a, r);
        act_q.push_back(r);
    endtask

    task automatic test_reset();
        rsp_t e, g;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; irq_src = 8'hFF;
        @(posedge clk); #1;
        n_cmp++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b0) begin
            n_err++; $display("FAIL reset_handshake: got %b want 00000", {awready, wready, arready, bvalid, rvalid});
        end
        n_cmp++;
        if ({rdata, bresp, rresp} !== 36'h0) begin
            n_err++; $display("FAIL reset_data: got rdata=%h bresp=%b rresp=%b want 0", rdata, bresp, rresp);
        end
        n_cmp++;
        if (irq !== 8'h00) begin n_err++; $display("FAIL reset_irq: got %h want 00", irq); end
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; irq_src = 8'h00;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        rd(A_PEND, 32'h0, OKAY);
        rd(A_EN, 32'h0, OKAY);
        rd(A_MODE, 32'h0, OKAY);
        rd(A_ACT, 32'h0, OKAY);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); g = '0;
            if (act_q.size() != 0) g = act_q.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL reset_regs: got data=%h resp=%b ok=%b want data=%h resp=%b ok=%b", g.data, g.resp, g.ok, e.data, e.resp, e.ok);
            end
        end
    endtask

    task automatic test_edge_eoi();
        rsp_t e, g;
        wr(A_EN, 32'h08, 4'hF, OKAY);
        wr(A_MODE, 32'h08, 4'hF, OKAY);
        irq_src[3] = 1'b1;
        @(posedge clk); #1;
        irq_src[3] = 1'b0;
        n_cmp++;
        if (irq !== 8'h00) begin n_err++; $display("FAIL edge_irq_n: got %h want 00", irq); end
        @(posedge clk); #1;
        n_cmp++;
        if (irq !== 8'h08) begin n_err++; $display("FAIL edge_irq_n1: got %h want 08", irq); end
        repeat (3) @(posedge clk);
        #1;
        rd(A_PEND, 32'h08, OKAY);
        n_cmp++;
        if (irq !== 8'h08) begin n_err++; $display("FAIL edge_irq_hold: got %h want 08", irq); end
        eoi[3] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        eoi[3] = 1'b0;
        n_cmp++;
        if (irq !== 8'h00) begin n_err++; $display("FAIL edge_eoi_irq: got %h want 00", irq); end
        rd(A_PEND, 32'h0, OKAY);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); g = '0;
            if (act_q.size() != 0) g = act_q.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL edge_axi: got data=%h resp=%b ok=%b want data=%h resp=%b ok=%b", g.data, g.resp, g.ok, e.data, e.resp, e.ok);
            end
        end
    endtask

    task automatic test_level_set_wins();
        rsp_t e, g;
        wr(A_MODE, 32'h00, 4'hF, OKAY);
        wr(A_EN, 32'h20, 4'hF, OKAY);
        irq_src[5] = 1'b1;
        @(posedge clk); #1;
        wr(A_PEND, 32'h20, 4'hF, OKAY);
        rd(A_PEND, 32'h20, OKAY);
        n_cmp++;
        if (irq !== 8'h20) begin n_err++; $display("FAIL level_irq: got %h want 20", irq); end
        irq_src[5] = 1'b0;
        @(posedge clk); #1;
        wr(A_PEND, 32'h20, 4'hF, OKAY);
        rd(A_PEND, 32'h0, OKAY);
        n_cmp++;
        if (irq !== 8'h00) begin n_err++; $display("FAIL level_irq_clr: got %h want 00", irq); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); g = '0;
            if (act_q.size() != 0) g = act_q.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL level_axi: got data=%h resp=%b ok=%b want data=%h resp=%b ok=%b", g.data, g.resp, g.ok, e.data, e.resp, e.ok);
            end
        end
    endtask

    task automatic test_enable_late();
        rsp_t e, g;
        wr(A_MODE, 32'h01, 4'hF, OKAY);
        wr(A_EN, 32'h00, 4'hF, OKAY);
        irq_src[0] = 1'b1;
        @(posedge clk); #1;
        irq_src[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (irq !== 8'h00) begin n_err++; $display("FAIL late_irq_masked: got %h want 00", irq); end
        rd(A_PEND, 32'h01, OKAY);
        wr(A_EN, 32'h01, 4'hF, OKAY);
        n_cmp++;
        if (irq !== 8'h01) begin n_err++; $display("FAIL late_irq_enabled: got %h want 01", irq); end
        rd(A_ACT, 32'h01, OKAY);
        wr(A_PEND, 32'h01, 4'hF, OKAY);
        rd(A_PEND, 32'h0, OKAY);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); g = '0;
            if (act_q.size() != 0) g = act_q.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL late_axi: got data=%h resp=%b ok=%b want data=%h resp=%b ok=%b", g.data, g.resp, g.ok, e.data, e.resp, e.ok);
            end
        end
    endtask

    task automatic test_unmapped_force();
        rsp_t e, g;
        rd(A_BAD, 32'h0, SLVERR);
`ifdef IRQ_CTRL_FORCE_EN
        wr(A_FORCE, 32'h02, 4'hF, OKAY);
        rd(A_PEND, 32'h02, OKAY);
        rd(A_FORCE, 32'h0, OKAY);
        wr(A_PEND, 32'h02, 4'hF, OKAY);
`else
        wr(A_FORCE, 32'h02, 4'hF, SLVERR);
        rd(A_PEND, 32'h0, OKAY);
        rd(A_FORCE, 32'h0, SLVERR);
`endif
        wr(A_BAD, 32'hFF, 4'hF, SLVERR);
        rd(A_EN, 32'h01, OKAY);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); g = '0;
            if (act_q.size() != 0) g = act_q.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL unmapped_axi: got data=%h resp=%b ok=%b want data=%h resp=%b ok=%b", g.data, g.resp, g.ok, e.data, e.resp, e.ok);
            end
        end
    endtask

    task automatic test_wstrb();
        rsp_t e, g;
        wr(A_EN, 32'h55, 4'hF, OKAY);
        wr(A_EN, 32'hFF, 4'h0, OKAY);
        rd(A_EN, 32'h55, OKAY);
        wr(A_EN, 32'hAA, 4'hE, OKAY);
        rd(A_EN, 32'h55, OKAY);
        wr(A_MODE, 32'h00, 4'hF, OKAY);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); g = '0;
            if (act_q.size() != 0) g = act_q.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL wstrb_axi: got data=%h resp=%b ok=%b want data=%h resp=%b ok=%b", g.data, g.resp, g.ok, e.data, e.resp, e.ok);
            end
        end
    endtask

    task automatic test_back_to_back();
        rsp_t e, g, rw, rr;
        irq_src[2] = 1'b1;
        @(posedge clk); #1;
        irq_src[2] = 1'b0;
        @(posedge clk); #1;
        fork
            bus_wr(A_PEND, 32'h04, 4'hF, rw);
            bus_rd(A_PEND, rr);
        join
        n_cmp++;
        if (rw !== '{data: 32'h0, resp: OKAY, ok: 1'b1}) begin
            n_err++; $display("FAIL b2b_wr: got resp=%b ok=%b want resp=00 ok=1", rw.resp, rw.ok);
        end
        n_cmp++;
        if (rr !== '{data: 32'h04, resp: OKAY, ok: 1'b1}) begin
            n_err++; $display("FAIL b2b_rd_prewrite: got data=%h resp=%b ok=%b want data=04 resp=00 ok=1", rr.data, rr.resp, rr.ok);
        end
        rd(A_PEND, 32'h0, OKAY);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); g = '0;
            if (act_q.size() != 0) g = act_q.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL b2b_axi: got data=%h resp=%b ok=%b want data=%h resp=%b ok=%b", g.data, g.resp, g.ok, e.data, e.resp, e.ok);
            end
        end
    endtask

    task automatic test_stall_reset();
        rsp_t e, g;
        bit   hs = 1'b0, bad = 1'b0, seen_b = 1'b0;
        irq_src[6] = 1'b1;
        @(posedge clk); #1;
        irq_src[6] = 1'b0;
        wr(A_MODE, 32'h01, 4'hF, OKAY);
        awaddr = A_EN; wdata = 32'hFF; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (awready && wready) begin hs = 1'b1; break; end
        end
        @(posedge clk); #1;
        wdata = 32'h0F;
        n_cmp++;
        if (!hs) begin n_err++; $display("FAIL stall_accept: got no aw/w handshake within 20 cycles, want one"); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!(bvalid === 1'b1 && awready === 1'b0 && wready === 1'b0)) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin n_err++; $display("FAIL stall_hold: got bvalid dropped or aw/w re-accepted, want bvalid=1 awready=0"); end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({bvalid, awready, wready, irq} !== 11'h0) begin
            n_err++; $display("FAIL stall_rst_outputs: got bvalid=%b awready=%b irq=%h want 0", bvalid, awready, irq);
        end
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bvalid) seen_b = 1'b1;
        end
        n_cmp++;
        if (seen_b) begin n_err++; $display("FAIL stall_no_resp: got bvalid after reset release, want none"); end
        bready = 1'b0;
        @(posedge clk); #1;
        rd(A_PEND, 32'h0, OKAY);
        rd(A_EN, 32'h0, OKAY);
        rd(A_MODE, 32'h0, OKAY);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); g = '0;
            if (act_q.size() != 0) g = act_q.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL stall_axi: got data=%h resp=%b ok=%b want data=%h resp=%b ok=%b", g.data, g.resp, g.ok, e.data, e.resp, e.ok);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running at 200us, want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_edge_eoi();
        test_level_set_wins();
        test_enable_late();
        test_unmapped_force();
        test_wstrb();
        test_back_to_back();
        test_stall_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/axi_irq_ctrl.md
AXI_IRQ_CTRL -- requirements
Module: axi_irq_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset.
REQ-002 SHALL have parameter AXI_ADDR_BW_p, default 12: AXI-lite address width.
REQ-003 SHALL have parameter IRQ_NBR_p, default 8: number of IRQ lines, legal range 1..32.
REQ-004 SHALL have port clk, input, 1: system clock.
REQ-005 SHALL have port rst, input, 1: asynchronous active-high reset.
REQ-006 SHALL have AXI-lite slave inputs i_axi_awaddr[AXI_ADDR_BW_p], i_axi_awvalid, i_axi_wdata[32], i_axi_wstrb[4], i_axi_wvalid, i_axi_bready, i_axi_araddr[AXI_ADDR_BW_p], i_axi_arvalid and i_axi_rready.
REQ-007 SHALL have AXI-lite slave outputs o_axi_awready, o_axi_wready, o_axi_bresp[2], o_axi_bvalid, o_axi_arready, o_axi_rdata[32], o_axi_rresp[2] and o_axi_rvalid.
REQ-008 SHALL have port i_irq_src, input, IRQ_NBR_p: peripheral interrupt sources (timer, UART, ...), synchronous to clk.
REQ-009 SHALL have port i_eoi, input, IRQ_NBR_p: end-of-interrupt from the CPU core.
REQ-010 SHALL have port o_irq, output, IRQ_NBR_p: interrupt lines to the CPU core irq vector.

Function
REQ-011 SHALL provide this register map (word offsets):
- 0x000 PENDING: read; write-1-to-clear.
- 0x004 ENABLE: read/write.
- 0x008 MODE: read/write; 1 = rising-edge, 0 = level.
- 0x00C FORCE: write-only, reads 0; write-1-to-set pending.
- 0x010 ACTIVE: read-only, PENDING & ENABLE.
- Bits at and above IRQ_NBR_p read 0 and ignore writes.
REQ-012 SHALL register i_irq_src into src_q each cycle; edge(i) = i_irq_src(i) & ~src_q(i).
REQ-013 SHALL set pending(i) at the clock edge where edge(i)=1 (MODE=1) or i_irq_src(i)=1 (MODE=0), independent of ENABLE.
REQ-014 SHALL clear pending(i) on a rising edge of i_eoi(i) (registered eoi_q) or on a PENDING write with wdata(i)=1 and its byte strobe set.
REQ-015 SHALL give set priority over clear when both occur in the same cycle; a level source still high therefore re-pends immediately.
REQ-016 SHALL drive o_irq as a registered copy of PENDING & ENABLE: source seen at edge N gives pending at N, o_irq high after edge N+1.
REQ-017 SHALL apply writes only to byte lanes whose i_axi_wstrb bit is 1.
REQ-018 SHALL use a write FSM IDLE->RESP: in IDLE, pulse awready and wready together for one cycle only when awvalid and wvalid are both 1; perform the write; go to RESP with bvalid=1; hold bvalid and bresp stable until bready; then return to IDLE.
REQ-019 SHALL use a read FSM IDLE->DATA: in IDLE, pulse arready one cycle on arvalid; capture rdata; hold rvalid, rdata and rresp until rready; then return to IDLE.
REQ-020 SHALL return OKAY (2'b00) for mapped offsets and SLVERR (2'b10) with no state change, and read data 0, for unmapped offsets.
REQ-021 SHALL allow read and write channels to progress concurrently; a read of PENDING in the cycle of a clearing write returns the pre-write value.

Reset
REQ-022 SHALL, while rst=1, asynchronously clear PENDING, ENABLE, MODE, src_q, eoi_q and o_irq to 0 and put both FSMs in IDLE.
REQ-023 SHALL, while rst=1, drive all AXI ready/valid outputs to 0 and rdata, bresp and rresp to 0.
REQ-024 SHALL abandon any outstanding AXI transaction on reset asserted mid-transfer; no response is issued after release.

Configuration
REQ-025 SHALL, with macro IRQ_CTRL_FORCE_EN defined, implement the FORCE register per REQ-011.
REQ-026 SHALL, without IRQ_CTRL_FORCE_EN defined, treat offset 0x00C as unmapped (SLVERR, no effect).

Verification
REQ-027 SHALL cover: ENABLE=0x08, MODE=0x08, 1-cycle pulse on i_irq_src[3] -> PENDING=0x08, o_irq[3]=1 two edges after the pulse, held until i_eoi[3] rises.
REQ-028 SHALL cover: MODE=0, ENABLE=0x20, i_irq_src[5] held high, write PENDING=0x20 -> pending stays 1 (set wins); drop source, then write -> PENDING=0.
REQ-029 SHALL cover: ENABLE=0, edge on i_irq_src[0] -> PENDING=0x01, o_irq=0; then write ENABLE=0x01 -> o_irq[0]=1 the next cycle.
REQ-030 SHALL cover: read 0x020 -> rresp=2'b10, rdata=0; write 0x00C=0x02 -> PENDING=0x02 with IRQ_CTRL_FORCE_EN defined, and SLVERR with PENDING unchanged without it.
REQ-031 SHALL cover: write with bready held 0 for 5 cycles -> bvalid stays 1, no new aw/w accepted; assert rst mid-wait -> bvalid=0 and all registers 0.
REQ-032 SHALL cover: write ENABLE=0xFF with wstrb=4'b0000 -> ENABLE unchanged, bresp=OKAY.
